// File: rtl/exotiny_uart_tx.sv
// exotiny_uart_tx: Wishbone byte sink that queues writes in a small FIFO and
// serialises them as 8N1 UART frames on tx_o (CLKDIV clocks per bit).
// Optional feature macro: EXOTINY_UART_DONE_DETECT_EN enables sticky
// "DONE"/"ERR" detectors on the accepted write byte stream (done_o/err_o).
module exotiny_uart_tx #(
    parameter int CLKDIV    = 16,
    parameter int FIFODEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [7:0]  wb_wdat_i,
    output logic [31:0] wb_rdat_o,
    output logic        wb_ack_o,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int PW = $clog2(FIFODEPTH);
    localparam int TW = $clog2(CLKDIV);
    localparam logic [TW-1:0] TMAX = TW'(CLKDIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shift, shift_n;
    logic            tx_n;
    logic            pop;

    logic [7:0]      mem [FIFODEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic            full, empty, busy;
    logic            accept, push;
    logic            ack;
    logic [31:0]     rdat;
    logic            tx;

    // full comes from the registered count, so a pop never unblocks a write in the same cycle
    assign full   = (count == (PW + 1)'(FIFODEPTH));
    assign empty  = (count == '0);
    assign busy   = !empty || (state != IDLE);
    assign accept = wb_stb_i && !ack && (!wb_we_i || !full);
    assign push   = accept && wb_we_i;

    assign wb_ack_o  = ack;
    assign wb_rdat_o = rdat;
    assign tx_o      = tx;
    assign busy_o    = busy;

    // Bus handshake: one-cycle ack after each accepted request, status captured on reads
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            ack  <= 1'b0;
            rdat <= '0;
        end else begin
            ack  <= accept;
            rdat <= (accept && !wb_we_i) ? {30'b0, full, busy} : 32'b0;
        end
    end

    // FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wb_wdat_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Transmitter state register; tx is registered so the line has no combinational path
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
        end
    end

    // Frame sequencing: each state holds for CLKDIV cycles, back-to-back frames chain from STOP
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                    timer_n = TMAX;
                    shift_n = mem[rd_ptr];
                end
            end
            START: begin
                if (timer == '0) begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                    timer_n   = TMAX;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            DATA: begin
                if (timer == '0) begin
                    timer_n = TMAX;
                    shift_n = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            STOP: begin
                if (timer == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = START;
                        timer_n = TMAX;
                        shift_n = mem[rd_ptr];
                    end else begin
                        state_n = IDLE;
                        timer_n = '0;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

`ifdef EXOTINY_UART_DONE_DETECT_EN
    logic [31:0] history;
    logic        done_q, err_q;

    // End-of-test detector: remembers the last four accepted bytes and latches the markers
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            history <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                history <= {history[23:0], wb_wdat_i};
            end
            if (history == 32'h444F4E45) begin
                done_q <= 1'b1;
            end
            if (history[23:0] == 24'h455252) begin
                err_q <= 1'b1;
            end
        end
    end

    assign done_o = done_q;
    assign err_o  = err_q;
`else
    assign done_o = 1'b0;
    assign err_o  = 1'b0;
`endif

endmodule
